// File: rtl/detect_scheduler_pkg.sv
// Shared encodings and defaults for the face-detect scheduler.
// Build option: DETECT_FILTER_EN selects a 3-result majority filter on face_present.
package detect_scheduler_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    LOCK  = 4'b0010,
    START = 4'b0100,
    BUSY  = 4'b1000
  } state_t;

  localparam int DEF_FRAME_DIV   = 4;
  localparam int DEF_LOCK_CYCLES = 4;
  localparam int DEF_TIMEOUT     = 64;
  localparam int DROP_CNT_W      = 8;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

endpackage

// File: rtl/detect_scheduler_if.sv
// Frame, button and classifier signals between the scheduler and its neighbours.
// master = scheduler side, slave = builder/classifier/button side.
interface detect_scheduler_if;
  import detect_scheduler_pkg::*;

  logic                  frame_done;
  logic                  btn_up;
  logic                  btn_down;
  logic                  detect_done;
  logic                  detected_flag;
  logic                  detect_en;
  logic                  increment_threshold;
  logic                  decrement_threshold;
  logic                  buf_lock;
  logic                  face_present;
  logic                  result_valid;
  logic                  timeout_err;
  logic [DROP_CNT_W-1:0] dropped_frames;

  modport master (
    input  frame_done, btn_up, btn_down, detect_done, detected_flag,
    output detect_en, increment_threshold, decrement_threshold, buf_lock,
           face_present, result_valid, timeout_err, dropped_frames
  );

  modport slave (
    output frame_done, btn_up, btn_down, detect_done, detected_flag,
    input  detect_en, increment_threshold, decrement_threshold, buf_lock,
           face_present, result_valid, timeout_err, dropped_frames
  );

endinterface

// File: rtl/detect_scheduler_btn_pulse_gate.sv
// Turns threshold button levels into single pulses, released only while the
// classifier is idle; simultaneous up/down requests cancel each other.
module btn_pulse_gate (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic idle_ok,
  output logic inc_pulse,
  output logic dec_pulse
);

  logic up_prev, down_prev;
  logic up_pend, down_pend;
  logic up_rise, down_rise;
  logic conflict, fire_up, fire_down;

  assign up_rise   = btn_up & ~up_prev;
  assign down_rise = btn_down & ~down_prev;
  assign conflict  = up_pend & down_pend;
  assign fire_up   = idle_ok & up_pend & ~down_pend;
  assign fire_down = idle_ok & down_pend & ~up_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      up_prev   <= 1'b0;
      down_prev <= 1'b0;
      up_pend   <= 1'b0;
      down_pend <= 1'b0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
    end else begin
      up_prev   <= btn_up;
      down_prev <= btn_down;
      // a new edge in the clearing cycle survives as a fresh request
      up_pend   <= (up_pend & ~conflict & ~fire_up) | up_rise;
      down_pend <= (down_pend & ~conflict & ~fire_down) | down_rise;
      inc_pulse <= fire_up;
      dec_pulse <= fire_down;
    end
  end

endmodule

// File: rtl/detect_scheduler.sv
// Frame-decimating sequencer: locks the integral buffer, runs the classifier with
// a timeout and publishes the result. Build option: DETECT_FILTER_EN.
//
//   state | meaning
//   IDLE  | counting frame_done pulses toward the next classified frame
//   LOCK  | buffer frozen, waiting for the writer pipeline to drain
//   START | one-cycle detect_en to the classifier
//   BUSY  | waiting for detect_done or timeout
module detect_scheduler
  import detect_scheduler_pkg::*;
#(
  parameter int FRAME_DIV   = DEF_FRAME_DIV,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input logic                clk,
  input logic                rst,
  detect_scheduler_if.master bus
);

  localparam logic [7:0]            FD_LAST   = 8'(FRAME_DIV - 1);
  localparam logic [7:0]            LOCK_LOAD = 8'(LOCK_CYCLES - 1);
  // loaded one below TIMEOUT so the abort lands exactly TIMEOUT cycles after detect_en
  localparam logic [15:0]           TMO_LOAD  = 16'(TIMEOUT - 1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX  = '1;

  state_t                state_q, state_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic [7:0]            lock_cnt_q, lock_cnt_d;
  logic [15:0]           tmo_cnt_q, tmo_cnt_d;
  logic                  result_now, timeout_now;
  logic                  face_next;
  logic                  detect_en_q, buf_lock_q, result_valid_q, timeout_err_q, face_q;
  logic [DROP_CNT_W-1:0] drop_q;
  logic                  idle_ok, inc_q, dec_q;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    result_now  = 1'b0;
    timeout_now = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.frame_done) begin
          if (frame_cnt_q == FD_LAST) begin
            frame_cnt_d = '0;
            lock_cnt_d  = LOCK_LOAD;
            state_d     = LOCK;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      LOCK: begin
        if (lock_cnt_q == '0) state_d = START;
        else                  lock_cnt_d = lock_cnt_q - 8'd1;
      end
      START: begin
        tmo_cnt_d = TMO_LOAD;
        state_d   = BUSY;
      end
      BUSY: begin
        if (bus.detect_done) begin
          result_now = 1'b1;
          state_d    = IDLE;
        end else if (tmo_cnt_q == 16'd1) begin
          timeout_now = 1'b1;
          state_d     = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DETECT_FILTER_EN
  logic [2:0] hist_q;

  always_ff @(posedge clk) begin
    if (rst)             hist_q <= '0;
    else if (result_now) hist_q <= {hist_q[1:0], bus.detected_flag};
  end

  assign face_next = maj3({hist_q[1:0], bus.detected_flag});
`else
  assign face_next = bus.detected_flag;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      frame_cnt_q    <= '0;
      lock_cnt_q     <= '0;
      tmo_cnt_q      <= '0;
      detect_en_q    <= 1'b0;
      buf_lock_q     <= 1'b0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      face_q         <= 1'b0;
      drop_q         <= '0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      lock_cnt_q     <= lock_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      detect_en_q    <= (state_d == START);
      buf_lock_q     <= (state_d != IDLE);
      result_valid_q <= result_now;
      if (timeout_now) timeout_err_q <= 1'b1;
      if (result_now)  face_q <= face_next;
      if (bus.frame_done && (state_q != IDLE) && (drop_q != DROP_MAX))
        drop_q <= drop_q + DROP_CNT_W'(1);
    end
  end

  // pulses may only be released from an IDLE cycle that is not leaving for LOCK
  assign idle_ok = (state_q == IDLE) && (state_d == IDLE);

  btn_pulse_gate u_btn (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (bus.btn_up),
    .btn_down (bus.btn_down),
    .idle_ok  (idle_ok),
    .inc_pulse(inc_q),
    .dec_pulse(dec_q)
  );

  assign bus.detect_en           = detect_en_q;
  assign bus.buf_lock            = buf_lock_q;
  assign bus.result_valid        = result_valid_q;
  assign bus.timeout_err         = timeout_err_q;
  assign bus.face_present        = face_q;
  assign bus.dropped_frames      = drop_q;
  assign bus.increment_threshold = inc_q;
  assign bus.decrement_threshold = dec_q;

endmodule

// File: doc/detect_scheduler.md
Name: detect_scheduler

Overview:
- Sequences the face classifier against the integral-image buffer.
- Each time the integral-image builder finishes a frame, decides whether that frame is classified (frame decimation).
- Freezes the buffer, starts the classifier, waits for completion or timeout, then publishes a registered detection result.
- Also converts raw threshold button levels into single pulses, delivered only while the classifier is idle.

Parameters:
FRAME_DIV, 4, classify every FRAME_DIV-th frame_done (1 = every frame); range 1..255
LOCK_CYCLES, 4, cycles buf_lock is held before detect_en is pulsed (lets the writer pipeline drain); range 1..255
TIMEOUT, 64, maximum cycles from detect_en pulse to detect_done before abort; range 16..65535

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
frame_done  in  1  one-cycle pulse from integral-image builder: buffer holds a complete frame
btn_up  in  1  synchronized button level: raise threshold
btn_down  in  1  synchronized button level: lower threshold
detect_done  in  1  classifier one-cycle completion pulse
detected_flag  in  1  classifier result, valid in the cycle detect_done=1
detect_en  out  1  one-cycle start pulse to classifier
increment_threshold  out  1  one-cycle pulse to classifier
decrement_threshold  out  1  one-cycle pulse to classifier
buf_lock  out  1  high = buffer writer must not write
face_present  out  1  latched detection result
result_valid  out  1  one-cycle pulse when face_present is updated
timeout_err  out  1  sticky; set on classifier timeout
dropped_frames  out  8  saturating count of frame_done pulses ignored while busy

Behaviour:
- Reset values: all outputs 0; frame counter 0; pending button flags cleared; FSM in IDLE.
- All outputs are registered.
- States (one-hot): IDLE, LOCK, START, BUSY.
- IDLE:
  - On frame_done, increment the frame counter.
  - If the counter reaches FRAME_DIV-1, clear it and go to LOCK; otherwise stay in IDLE.
- LOCK:
  - buf_lock=1.
  - Count LOCK_CYCLES cycles, then go to START.
- START:
  - detect_en=1 for exactly this one cycle.
  - Load the timeout counter with TIMEOUT; go to BUSY.
- BUSY:
  - Decrement the timeout counter each cycle.
  - On detect_done=1, in the next cycle:
    - face_present <= detected_flag sampled in the detect_done cycle;
    - result_valid=1 for one cycle;
    - buf_lock=0;
    - go to IDLE.
  - If the counter reaches 0 with no detect_done: timeout_err<=1 (sticky until rst), buf_lock=0, face_present unchanged, no result_valid, go to IDLE.
- buf_lock:
  - High from the LOCK-entry cycle through the last BUSY cycle.
  - Total latency from the qualifying frame_done to detect_en is LOCK_CYCLES+1 cycles.
- frame_done outside IDLE:
  - Ignored for frame counting.
  - dropped_frames increments, saturating at 255.
- Button handling:
  - A rising edge of btn_up or btn_down (registered previous level) sets a pending flag.
  - The pending flag is emitted as a one-cycle increment_/decrement_threshold pulse only in IDLE, and never in a cycle where IDLE exits to LOCK.
  - The flag clears when its pulse is emitted.
  - Both flags pending in the same cycle: both cleared, no pulse.
  - A held button produces exactly one pulse.
- detect_done in IDLE, LOCK or START: ignored.
- rst mid-operation: immediately returns to IDLE; buf_lock drops in the next cycle; pending pulses are lost.

Optional Feature:
- Macro: DETECT_FILTER_EN.
- Defined:
  - face_present is the majority of the last 3 completed results, held in a 3-bit shift register cleared by rst.
  - result_valid still pulses on every completed result.
  - Timeouts do not shift the register.
- Undefined: face_present is the raw latest result and the shift register is absent.

Decomposition:
- Shared package holds:
  - state encodings (IDLE=4'b0001, LOCK=4'b0010, START=4'b0100, BUSY=4'b1000);
  - default FRAME_DIV, LOCK_CYCLES and TIMEOUT;
  - DROP_CNT_W=8.
- One natural sub-module, btn_pulse_gate: edge detection, pending flags, idle gating and conflict cancel for the two threshold buttons.

Test Plan:
- FRAME_DIV=4, four frame_done pulses 20 cycles apart:
  - detect_en only after the 4th pulse, 5 cycles later with LOCK_CYCLES=4;
  - buf_lock high from the cycle after the 4th pulse.
- Classifier model answers detect_done=1, detected_flag=1 ten cycles after detect_en:
  - face_present=1 and result_valid pulse in the next cycle;
  - buf_lock=0 in the same cycle as result_valid.
- No detect_done, TIMEOUT=64:
  - timeout_err=1 and buf_lock=0 64 cycles after detect_en;
  - face_present unchanged; a new frame sequence still runs.
- Three frame_done pulses during BUSY: dropped_frames=3; FSM returns to IDLE with the frame counter unchanged.
- btn_up held 100 cycles during BUSY:
  - no increment_threshold until return to IDLE, then exactly one 1-cycle pulse;
  - btn_up and btn_down rising in the same cycle produce no pulse.
- DETECT_FILTER_EN defined, result sequence 1,0,1,0,0: face_present is 0,0,1,0,0 after each result_valid.
